punc_mem_seq: RTL

//  Parametrised memory-access sequencer for the PUnC datapath. Executes LD/LDR, LDI, ST/STR
//  and STI as explicit multi-cycle sequences with a registered indirect pointer.

---
 rtl/punc_mem_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/punc_mem_seq.sv
// punc_mem_seq: multi-cycle memory-access sequencer for the PUnC datapath.
// Runs LD, LDI, ST and STI as explicit read/write sequences against a
// unified memory with read latency MEM_RD_LAT (1..4). Indirect pointers come
// from the low ADDR_W bits of the word read (requires ADDR_W <= DATA_W).
// Optional feature: define PUNC_MEM_BOUNDS_CHECK_EN to suppress any access
// at addr >= MEM_DEPTH and answer it with resp_fault=1, resp_data=0.
module punc_mem_seq #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int MEM_DEPTH  = 1024,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_r_data
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_PTR    = 3'd1;
    localparam logic [2:0] S_WAIT_PTR  = 3'd2;
    localparam logic [2:0] S_RD_DATA   = 3'd3;
    localparam logic [2:0] S_WAIT_DATA = 3'd4;
    localparam logic [2:0] S_WR        = 3'd5;
    localparam logic [2:0] S_RESP      = 3'd6;

    localparam logic [1:0] OP_LD  = 2'd0;
    localparam logic [1:0] OP_LDI = 2'd1;
    localparam logic [1:0] OP_ST  = 2'd2;
    localparam logic [1:0] OP_STI = 2'd3;

    logic [2:0]        state;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] ptr;       // current access address (direct or indirect)
    logic [2:0]        lat_cnt;   // read-latency counter, 1..MEM_RD_LAT
    logic              fault_q;
    logic              lat_done;
    logic [ADDR_W-1:0] rd_ptr;
    logic              req_oob;
    logic              ptr_oob;

    assign lat_done = (lat_cnt == 3'(MEM_RD_LAT));
    assign rd_ptr   = mem_r_data[ADDR_W-1:0];

`ifdef PUNC_MEM_BOUNDS_CHECK_EN
    // Compare one bit wider so MEM_DEPTH == 2^ADDR_W never aliases to 0.
    assign req_oob    = ({1'b0, req_addr} >= (ADDR_W+1)'(MEM_DEPTH));
    assign ptr_oob    = ({1'b0, rd_ptr}   >= (ADDR_W+1)'(MEM_DEPTH));
    assign resp_fault = fault_q;
`else
    // No check: fault_q can never set, and the output is tied low.
    assign req_oob    = 1'b0;
    assign ptr_oob    = 1'b0;
    assign resp_fault = 1'b0;
`endif

    // Sequencer FSM: request capture, read/write sequencing, response hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= 3'd0;
            wdata_q   <= '0;
            ptr       <= '0;
            lat_cnt   <= 3'd0;
            resp_data <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        wdata_q   <= req_wdata;
                        ptr       <= req_addr;
                        resp_data <= '0;
                        fault_q   <= 1'b0;
                        if (req_op[2]) begin
                            state <= S_RESP;            // reserved op: data 0
                        end else if (req_oob) begin
                            fault_q <= 1'b1;
                            state   <= S_RESP;
                        end else begin
                            case (req_op[1:0])
                                OP_LD:   state <= S_RD_DATA;
                                OP_ST:   state <= S_WR;
                                default: state <= S_RD_PTR;  // LDI, STI
                            endcase
                        end
                    end
                end
                S_RD_PTR: begin
                    lat_cnt <= 3'd1;
                    state   <= S_WAIT_PTR;
                end
                S_WAIT_PTR: begin
                    if (lat_done) begin
                        ptr <= rd_ptr;
                        if (ptr_oob) begin
                            fault_q <= 1'b1;
                            state   <= S_RESP;
                        end else if (op_q[1:0] == OP_LDI) begin
                            state <= S_RD_DATA;
                        end else begin
                            state <= S_WR;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                S_RD_DATA: begin
                    lat_cnt <= 3'd1;
                    state   <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    if (lat_done) begin
                        resp_data <= mem_r_data;
                        state     <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                S_WR: begin
                    resp_data <= wdata_q;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        fault_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes and handshakes decode straight from state; rd and wr states are disjoint.
    always_comb begin
        req_ready   = (state == S_IDLE);
        resp_valid  = (state == S_RESP);
        mem_rd_en   = (state == S_RD_PTR) || (state == S_RD_DATA);
        mem_wr_en   = (state == S_WR);
        mem_addr    = (mem_rd_en || mem_wr_en) ? ptr : '0;
        mem_wr_data = mem_wr_en ? wdata_q : '0;
    end

    // op_q[2] only matters in IDLE (via req_op); keep it registered for completeness.
    logic unused_op;
    assign unused_op = op_q[2];
endmodule
